// File: rtl/wb_arb.sv
// ============================================================================
// Module   : wb_arb
// Brief    : Round-robin write-back arbiter for a 32x32 register file with a
//            pending-write scoreboard. Optional forwarding: WB_ARB_FWD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arb #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic [AW-1:0]     i_req0_reg,
  input  logic [DW-1:0]     i_req0_val,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [AW-1:0]     i_req1_reg,
  input  logic [DW-1:0]     i_req1_val,
  output logic              o_req1_ready,
  input  logic              i_iss_valid,
  input  logic [AW-1:0]     i_iss_reg,
  output logic              o_iss_ready,
  output logic [2**AW-1:0]  o_pending,
`ifdef WB_ARB_FWD_EN
  output logic              o_fwd_valid,
  output logic [AW-1:0]     o_fwd_reg,
  output logic [DW-1:0]     o_fwd_val,
`endif
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_reg,
  output logic [DW-1:0]     o_wb_val
);

  localparam int C_NREG = 2**AW;

  logic              r_rr;          // 0: port 0 preferred, 1: port 1 preferred
  logic [C_NREG-1:0] r_pending;
  logic              r_wb_we;
  logic [AW-1:0]     r_wb_reg;
  logic [DW-1:0]     r_wb_val;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic [AW-1:0]     w_sel_reg;
  logic [DW-1:0]     w_sel_val;
  logic              w_iss_ready;
  logic              w_claim;
  logic [C_NREG-1:0] w_pend_nxt;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_rst) begin
      if (i_req0_valid && (!i_req1_valid || !r_rr)) begin
        w_gnt0 = 1'b1;
      end else if (i_req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_xfer    = w_gnt0 | w_gnt1;
  assign w_sel_reg = w_gnt1 ? i_req1_reg : i_req0_reg;
  assign w_sel_val = w_gnt1 ? i_req1_val : i_req0_val;

  // Readiness looks at the pre-clear bit so a retiring producer cannot
  // be overtaken by a new claim on the same register in the same cycle.
  assign w_iss_ready = ~r_pending[i_iss_reg] | (i_iss_reg == '0);
  assign w_claim     = i_iss_valid & w_iss_ready;

  // Set is applied after clear so a new producer wins a same-cycle collision.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_xfer) begin
      w_pend_nxt[w_sel_reg] = 1'b0;
    end
    if (w_claim) begin
      w_pend_nxt[i_iss_reg] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr      <= 1'b0;
      r_pending <= '0;
      r_wb_we   <= 1'b0;
      r_wb_reg  <= '0;
      r_wb_val  <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_wb_we   <= w_xfer && (w_sel_reg != '0);
      if (w_xfer) begin
        r_wb_reg <= w_sel_reg;
        r_wb_val <= w_sel_val;
        r_rr     <= w_gnt0;
      end
    end
  end

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;
  assign o_iss_ready  = w_iss_ready;
  assign o_pending    = r_pending;
  assign o_wb_we      = r_wb_we;
  assign o_wb_reg     = r_wb_reg;
  assign o_wb_val     = r_wb_val;

`ifdef WB_ARB_FWD_EN
  assign o_fwd_valid = w_xfer && (w_sel_reg != '0);
  assign o_fwd_reg   = w_sel_reg;
  assign o_fwd_val   = w_sel_val;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arb.sv
// ============================================================================
// Module   : tb_wb_arb
// Brief    : Directed plus randomized bench for wb_arb against a queue/array
//            reference model of the write-back and scoreboard rules.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arb;

  logic        clk;
  logic        rst;
  logic        r0v, r1v, isv;
  logic [4:0]  r0r, r1r, isr;
  logic [31:0] r0d, r1d;
  logic        r0rdy, r1rdy, isrdy;
  logic [31:0] pend;
  logic        we;
  logic [4:0]  wreg;
  logic [31:0] wval;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_pend [32];
  int          m_pref;          // port number preferred on a tie
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_val;
  bit          g0, g1;          // model grant of the last evaluated cycle

  wb_arb #(.DW(32), .AW(5)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(r0v), .i_req0_reg(r0r), .i_req0_val(r0d), .o_req0_ready(r0rdy),
    .i_req1_valid(r1v), .i_req1_reg(r1r), .i_req1_val(r1d), .o_req1_ready(r1rdy),
    .i_iss_valid(isv), .i_iss_reg(isr), .o_iss_ready(isrdy),
    .o_pending(pend),
    .o_wb_we(we), .o_wb_reg(wreg), .o_wb_val(wval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One clock: check combinational outputs before the edge, advance the
  // model, then check registered outputs just after the edge.
  task automatic cycle();
    bit exp_iss;
    int gport;
    #1;
    g0 = 0; g1 = 0;
    if (!rst) begin
      if (r0v && r1v) begin
        if (m_pref == 0) g0 = 1; else g1 = 1;
      end else begin
        g0 = r0v;
        g1 = r1v;
      end
    end
    chk("req0_ready", r0rdy, g0);
    chk("req1_ready", r1rdy, g1);
    exp_iss = (!m_pend[isr]) || (isr == 0);
    if (!rst) chk("iss_ready", isrdy, exp_iss);

    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_pref = 0; m_we = 0; m_reg = 0; m_val = 0;
    end else begin
      m_we = 0;
      if (g0 || g1) begin
        gport  = g1 ? 1 : 0;
        m_reg  = g1 ? r1r : r0r;
        m_val  = g1 ? r1d : r0d;
        m_we   = (m_reg != 0);
        m_pend[m_reg] = 0;
        m_pref = 1 - gport;
      end
      if (isv && exp_iss && isr != 0) m_pend[isr] = 1;
    end

    @(posedge clk);
    #1;
    chk("wb_we", we, m_we);
    chk("wb_reg", wreg, m_reg);
    chk("wb_val", wval, m_val);
    chk("pending", pend, model_pend_vec());
  endtask

  initial begin
    int rnd_cycles;
    rst = 1; r0v = 0; r1v = 0; isv = 0;
    r0r = 0; r1r = 0; isr = 0; r0d = 0; r1d = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
    m_pref = 0; m_we = 0; m_reg = 0; m_val = 0;
    @(posedge clk); #1;
    cycle();
    cycle();
    chk("rst_pending", pend, 32'h0);
    chk("rst_we", we, 1'b0);
    rst = 0;

    // single ALU write, 1-cycle latency
    r0v = 1; r0r = 5; r0d = 32'hDEADBEEF;
    cycle();
    chk("t1_grant0", g0, 1'b1);
    chk("t1_we", we, 1'b1);
    chk("t1_reg", wreg, 5'd5);
    chk("t1_val", wval, 32'hDEADBEEF);
    r0v = 0;
    cycle();
    chk("t1_we_drop", we, 1'b0);

    // LSU write to reg 0 is consumed silently
    r1v = 1; r1r = 0; r1d = 32'h1234;
    cycle();
    chk("t3_ready", g1, 1'b1);
    chk("t3_we", we, 1'b0);
    r1v = 0;
    cycle();
    chk("t3_we2", we, 1'b0);

    // both valid: strict alternation 0,1,0,1
    r0v = 1; r0r = 1; r0d = 32'h11; r1v = 1; r1r = 2; r1d = 32'h22;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t2_reg", wreg, (k % 2 == 0) ? 5'd1 : 5'd2);
      chk("t2_we", we, 1'b1);
    end
    r0v = 0; r1v = 0;

    // claim / WAW block / clear by write-back
    isv = 1; isr = 7;
    cycle();
    chk("t4_set", pend[7], 1'b1);
    #1 chk("t4_waw", isrdy, 1'b0);
    cycle();
    isv = 0; r0v = 1; r0r = 7; r0d = 32'h77;
    cycle();
    chk("t4_clear", pend[7], 1'b0);
    r0v = 0; isv = 1; isr = 7;
    #1 chk("t4_reissue", isrdy, 1'b1);
    cycle();

    // same-cycle claim and write-back on reg 3
    isr = 3;
    cycle();
    r1v = 1; r1r = 3; r1d = 32'h33;
    #1 chk("t5_blocked", isrdy, 1'b0);
    cycle();
    chk("t5_cleared", pend[3], 1'b0);
    #1 chk("t5_free", isrdy, 1'b1);
    cycle();
    chk("t5_newwins", pend[3], 1'b1);
    r1v = 0;

    // fill scoreboard, then reset under contention
    for (int n = 1; n < 32; n++) begin
      isr = n[4:0];
      cycle();
    end
    isv = 0;
    chk("t6_full", pend, 32'hFFFF_FFFE);
    r0v = 1; r0r = 9; r0d = 32'h99; r1v = 1; r1r = 10; r1d = 32'hAA;
    rst = 1;
    cycle();
    chk("t6_rst_pend", pend, 32'h0);
    chk("t6_rst_we", we, 1'b0);
    rst = 0;
    #1;
    chk("t6_first0", r0rdy, 1'b1);
    chk("t6_first1", r1rdy, 1'b0);
    cycle();
    chk("t6_wreg", wreg, 5'd9);
    r0v = 0;
    cycle();
    r1v = 0;

    // randomized traffic; requesters hold until granted
    rnd_cycles = 400;
    for (int c = 0; c < rnd_cycles; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!r0v && $urandom_range(0, 2) != 0) begin
        r0v = 1; r0r = 5'($urandom_range(0, 7)); r0d = $urandom;
      end
      if (!r1v && $urandom_range(0, 2) != 0) begin
        r1v = 1; r1r = 5'($urandom_range(0, 7)); r1d = $urandom;
      end
      isv = ($urandom_range(0, 1) == 1);
      isr = 5'($urandom_range(0, 7));
      cycle();
      if (g0) r0v = 0;
      if (g1) r1v = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
